// File: rtl/store_narrow_unit_if.sv
// Handshake bundle between the MEM stage, the store narrowing unit and data memory.
// The slave modport is the unit's view; the master modport is the environment's view.
interface store_narrow_unit_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        done;
  logic        misalign_err;

  modport slave (
    input  st_valid, st_addr, st_data, st_size, mem_ready,
    output st_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, misalign_err
  );

  modport master (
    output st_valid, st_addr, st_data, st_size, mem_ready,
    input  st_ready, mem_valid, mem_addr, mem_wdata, mem_be, done, misalign_err
  );
endinterface

// File: rtl/store_narrow_unit.sv
// Store-side narrowing for the MEM stage: lane-steers SB/SH/SW data with byte enables
// and writes it to memory in one or two word beats.
module store_narrow_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter bit BIG_ENDIAN       = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  store_narrow_unit_if.slave   bus,
  output logic [1:0]           state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both 1.
  // st_* is accepted only in IDLE; mem_* outputs are held stable while mem_ready is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT1 = 2'd1,
    BEAT2 = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic [31:0] addr2_q, wdata2_q;
  logic [3:0]  be2_q;
  logic        need2_q;
  logic        done_q, err_q;

  logic [7:0]  mask_n;
  logic [31:0] data_n;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic        need2, req_err;
  logic [31:0] beat1_addr;
  logic [3:0]  be1_c, be2_c;
  logic [31:0] w1_c, w2_c;

  logic load1, adv, done_d, err_d;

  function automatic logic [3:0] rev_be(input logic [3:0] b);
    return {b[0], b[1], b[2], b[3]};
  endfunction

  function automatic logic [31:0] rev_w(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Request decode: narrow, then shift both mask and data by the byte offset into a
  // 64-bit window whose upper half is the second word.
  always_comb begin
    mask_n = 8'h00;
    data_n = 32'd0;
    case (bus.st_size)
      2'b00: begin mask_n = 8'h01; data_n = {24'd0, bus.st_data[7:0]};  end
      2'b01: begin mask_n = 8'h03; data_n = {16'd0, bus.st_data[15:0]}; end
      2'b10: begin mask_n = 8'h0F; data_n = bus.st_data;                end
      default: begin mask_n = 8'h00; data_n = 32'd0;                    end
    endcase
  end

  assign mask8      = mask_n << bus.st_addr[1:0];
  assign data64     = {32'd0, data_n} << {bus.st_addr[1:0], 3'b000};
  assign need2      = |mask8[7:4];
  assign req_err    = (bus.st_size == 2'b11) || (!ALLOW_MISALIGNED && need2);
  assign beat1_addr = {bus.st_addr[31:2], 2'b00};

  assign be1_c = BIG_ENDIAN ? rev_be(mask8[3:0])    : mask8[3:0];
  assign be2_c = BIG_ENDIAN ? rev_be(mask8[7:4])    : mask8[7:4];
  assign w1_c  = BIG_ENDIAN ? rev_w(data64[31:0])   : data64[31:0];
  assign w2_c  = BIG_ENDIAN ? rev_w(data64[63:32])  : data64[63:32];

  always_comb begin
    state_d = state_q;
    load1   = 1'b0;
    adv     = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.st_valid) begin
          if (req_err) begin
            err_d = 1'b1;
          end else begin
            load1   = 1'b1;
            state_d = BEAT1;
          end
        end
      end
      BEAT1: begin
        if (bus.mem_ready) begin
          if (need2_q) begin
            adv     = 1'b1;
            state_d = BEAT2;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BEAT2: begin
        if (bus.mem_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      addr2_q  <= 32'd0;
      wdata2_q <= 32'd0;
      be2_q    <= 4'd0;
      need2_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (load1) begin
        addr_q   <= beat1_addr;
        wdata_q  <= w1_c;
        be_q     <= be1_c;
        addr2_q  <= beat1_addr + 32'd4;
        wdata2_q <= w2_c;
        be2_q    <= be2_c;
        need2_q  <= need2;
      end else if (adv) begin
        addr_q   <= addr2_q;
        wdata_q  <= wdata2_q;
        be_q     <= be2_q;
      end else if (done_d) begin
        // Park the bus at zero once the store has completed.
        addr_q   <= 32'd0;
        wdata_q  <= 32'd0;
        be_q     <= 4'd0;
      end
    end
  end

  assign bus.st_ready     = (state_q == IDLE);
  assign bus.mem_valid    = (state_q != IDLE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_be       = be_q;
  assign bus.done         = done_q;
  assign bus.misalign_err = err_q;
  assign state_dbg        = state_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: vector table on the default build, plus
// hand sequences for strict-alignment, big-endian, stall/wrap and reset abort.
module tb_store_narrow_unit;

  logic clk;
  logic reset;
  logic [1:0] st0, st1, st2;

  store_narrow_unit_if a0 ();
  store_narrow_unit_if a1 ();
  store_narrow_unit_if a2 ();

  store_narrow_unit #(.ALLOW_MISALIGNED(1'b1), .BIG_ENDIAN(1'b0)) u0 (
    .clk(clk), .reset(reset), .bus(a0.slave), .state_dbg(st0));
  store_narrow_unit #(.ALLOW_MISALIGNED(1'b0), .BIG_ENDIAN(1'b0)) u1 (
    .clk(clk), .reset(reset), .bus(a1.slave), .state_dbg(st1));
  store_narrow_unit #(.ALLOW_MISALIGNED(1'b1), .BIG_ENDIAN(1'b1)) u2 (
    .clk(clk), .reset(reset), .bus(a2.slave), .state_dbg(st2));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        two;
    logic [31:0] a1;
    logic [3:0]  b1;
    logic [31:0] w1;
    logic [31:0] a2;
    logic [3:0]  b2;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs[10];

  // driver: one store on u0 with mem_ready held high, all beats checked
  task automatic do_store(input vec_t v);
    @(negedge clk);
    check("pre_ready", {31'd0, a0.st_ready}, 32'd1);
    a0.st_valid = 1'b1;
    a0.st_addr  = v.addr;
    a0.st_data  = v.data;
    a0.st_size  = v.size;
    @(negedge clk);
    a0.st_valid = 1'b0;
    if (v.err) begin
      check("err_pulse",  {31'd0, a0.misalign_err}, 32'd1);
      check("err_nomem",  {31'd0, a0.mem_valid}, 32'd0);
      check("err_ready",  {31'd0, a0.st_ready}, 32'd1);
      @(negedge clk);
      check("err_clear",  {31'd0, a0.misalign_err}, 32'd0);
      check("err_nodone", {31'd0, a0.done}, 32'd0);
      return;
    end
    check("b1_valid", {31'd0, a0.mem_valid}, 32'd1);
    check("b1_addr",  a0.mem_addr, v.a1);
    check("b1_be",    {28'd0, a0.mem_be}, {28'd0, v.b1});
    check("b1_wdata", a0.mem_wdata, v.w1);
    check("b1_nodone", {31'd0, a0.done}, 32'd0);
    @(negedge clk);
    if (v.two) begin
      check("b2_valid", {31'd0, a0.mem_valid}, 32'd1);
      check("b2_addr",  a0.mem_addr, v.a2);
      check("b2_be",    {28'd0, a0.mem_be}, {28'd0, v.b2});
      check("b2_wdata", a0.mem_wdata, v.w2);
      check("b2_nodone", {31'd0, a0.done}, 32'd0);
      @(negedge clk);
    end
    check("done",       {31'd0, a0.done}, 32'd1);
    check("done_ready", {31'd0, a0.st_ready}, 32'd1);
    check("done_idle",  {31'd0, a0.mem_valid}, 32'd0);
    @(negedge clk);
    check("done_once",  {31'd0, a0.done}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{2'b00, 32'h0000_1003, 32'hDEAD_BEEF, 1'b0, 1'b0,
                32'h0000_1000, 4'b1000, 32'hEF00_0000, 32'h0, 4'h0, 32'h0};
    vecs[1] = '{2'b01, 32'h0000_2002, 32'h0000_8001, 1'b0, 1'b0,
                32'h0000_2000, 4'b1100, 32'h8001_0000, 32'h0, 4'h0, 32'h0};
    vecs[2] = '{2'b01, 32'h0000_2002, 32'hFFFF_8001, 1'b0, 1'b0,
                32'h0000_2000, 4'b1100, 32'h8001_0000, 32'h0, 4'h0, 32'h0};
    vecs[3] = '{2'b10, 32'h0000_3001, 32'h1122_3344, 1'b0, 1'b1,
                32'h0000_3000, 4'b1110, 32'h2233_4400, 32'h0000_3004, 4'b0001, 32'h0000_0011};
    vecs[4] = '{2'b10, 32'h0000_4000, 32'hCAFE_BABE, 1'b0, 1'b0,
                32'h0000_4000, 4'b1111, 32'hCAFE_BABE, 32'h0, 4'h0, 32'h0};
    vecs[5] = '{2'b00, 32'h0000_5000, 32'h1234_5678, 1'b0, 1'b0,
                32'h0000_5000, 4'b0001, 32'h0000_0078, 32'h0, 4'h0, 32'h0};
    vecs[6] = '{2'b01, 32'h0000_6003, 32'h0000_BEEF, 1'b0, 1'b1,
                32'h0000_6000, 4'b1000, 32'hEF00_0000, 32'h0000_6004, 4'b0001, 32'h0000_00BE};
    vecs[7] = '{2'b11, 32'h0000_7000, 32'h5555_5555, 1'b1, 1'b0,
                32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
    vecs[8] = '{2'b10, 32'h0000_8002, 32'hA1B2_C3D4, 1'b0, 1'b1,
                32'h0000_8000, 4'b1100, 32'hC3D4_0000, 32'h0000_8004, 4'b0011, 32'h0000_A1B2};
    vecs[9] = '{2'b00, 32'h0000_9001, 32'h0000_00AA, 1'b0, 1'b0,
                32'h0000_9000, 4'b0010, 32'h0000_AA00, 32'h0, 4'h0, 32'h0};

    a0.st_valid = 0; a0.st_addr = 0; a0.st_data = 0; a0.st_size = 0; a0.mem_ready = 1;
    a1.st_valid = 0; a1.st_addr = 0; a1.st_data = 0; a1.st_size = 0; a1.mem_ready = 1;
    a2.st_valid = 0; a2.st_addr = 0; a2.st_data = 0; a2.st_size = 0; a2.mem_ready = 1;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // reset state
    check("rst_ready",  {31'd0, a0.st_ready}, 32'd1);
    check("rst_valid",  {31'd0, a0.mem_valid}, 32'd0);
    check("rst_addr",   a0.mem_addr, 32'd0);
    check("rst_wdata",  a0.mem_wdata, 32'd0);
    check("rst_be",     {28'd0, a0.mem_be}, 32'd0);
    check("rst_done",   {31'd0, a0.done}, 32'd0);
    check("rst_err",    {31'd0, a0.misalign_err}, 32'd0);
    check("rst_state",  {30'd0, st0}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) do_store(vecs[i]);

    // back-to-back: new request accepted in the done cycle
    @(negedge clk);
    a0.st_valid = 1; a0.st_addr = 32'h0000_0104; a0.st_data = 32'h0000_0033; a0.st_size = 2'b00;
    @(negedge clk);
    a0.st_addr = 32'h0000_0201; a0.st_data = 32'h0000_0044;
    @(negedge clk);
    check("b2b_done",  {31'd0, a0.done}, 32'd1);
    check("b2b_ready", {31'd0, a0.st_ready}, 32'd1);
    @(negedge clk);
    a0.st_valid = 0;
    check("b2b_valid", {31'd0, a0.mem_valid}, 32'd1);
    check("b2b_addr",  a0.mem_addr, 32'h0000_0200);
    check("b2b_be",    {28'd0, a0.mem_be}, 32'h2);
    check("b2b_wdata", a0.mem_wdata, 32'h0000_4400);
    @(negedge clk);
    check("b2b_done2", {31'd0, a0.done}, 32'd1);

    // strict alignment build: misaligned SW and reserved size rejected, aligned SW fine
    @(negedge clk);
    a1.st_valid = 1; a1.st_addr = 32'h0000_3001; a1.st_data = 32'h1122_3344; a1.st_size = 2'b10;
    @(negedge clk);
    a1.st_valid = 0;
    check("strict_err",   {31'd0, a1.misalign_err}, 32'd1);
    check("strict_ready", {31'd0, a1.st_ready}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("strict_nomem", {31'd0, a1.mem_valid}, 32'd0);
      check("strict_nodone", {31'd0, a1.done}, 32'd0);
      check("strict_errlow", {31'd0, a1.misalign_err}, 32'd0);
    end
    a1.st_valid = 1; a1.st_addr = 32'h0000_3000; a1.st_size = 2'b11;
    @(negedge clk);
    a1.st_valid = 0;
    check("rsv_err",   {31'd0, a1.misalign_err}, 32'd1);
    check("rsv_nomem", {31'd0, a1.mem_valid}, 32'd0);
    a1.st_valid = 1; a1.st_addr = 32'h0000_0100; a1.st_data = 32'h0BAD_F00D; a1.st_size = 2'b10;
    @(negedge clk);
    a1.st_valid = 0;
    check("strict_ok_valid", {31'd0, a1.mem_valid}, 32'd1);
    check("strict_ok_be",    {28'd0, a1.mem_be}, 32'hF);
    check("strict_ok_wdata", a1.mem_wdata, 32'h0BAD_F00D);
    @(negedge clk);
    check("strict_ok_done", {31'd0, a1.done}, 32'd1);

    // big-endian build
    a2.st_valid = 1; a2.st_addr = 32'h0; a2.st_data = 32'h0000_00AB; a2.st_size = 2'b00;
    @(negedge clk);
    a2.st_valid = 0;
    check("be_sb_be",    {28'd0, a2.mem_be}, 32'h8);
    check("be_sb_wdata", a2.mem_wdata, 32'hAB00_0000);
    @(negedge clk);
    a2.st_valid = 1; a2.st_addr = 32'h0000_0010; a2.st_data = 32'h0000_1234; a2.st_size = 2'b01;
    @(negedge clk);
    a2.st_valid = 0;
    check("be_sh_addr",  a2.mem_addr, 32'h0000_0010);
    check("be_sh_be",    {28'd0, a2.mem_be}, 32'hC);
    check("be_sh_wdata", a2.mem_wdata, 32'h3412_0000);
    @(negedge clk);

    // stall with address wrap, then reset during the second beat's stall
    a0.mem_ready = 0;
    a0.st_valid = 1; a0.st_addr = 32'hFFFF_FFFE; a0.st_data = 32'hA1B2_C3D4; a0.st_size = 2'b10;
    @(negedge clk);
    a0.st_valid = 0;
    for (int k = 0; k < 3; k++) begin
      check("stall1_valid", {31'd0, a0.mem_valid}, 32'd1);
      check("stall1_addr",  a0.mem_addr, 32'hFFFF_FFFC);
      check("stall1_be",    {28'd0, a0.mem_be}, 32'hC);
      check("stall1_wdata", a0.mem_wdata, 32'hC3D4_0000);
      if (k == 2) a0.mem_ready = 1;
      @(negedge clk);
    end
    a0.mem_ready = 0;
    for (int k = 0; k < 2; k++) begin
      check("stall2_valid", {31'd0, a0.mem_valid}, 32'd1);
      check("stall2_addr",  a0.mem_addr, 32'h0000_0000);
      check("stall2_be",    {28'd0, a0.mem_be}, 32'h3);
      check("stall2_wdata", a0.mem_wdata, 32'h0000_A1B2);
      check("stall2_nodone", {31'd0, a0.done}, 32'd0);
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, a0.mem_valid}, 32'd0);
    check("abort_ready", {31'd0, a0.st_ready}, 32'd1);
    check("abort_done",  {31'd0, a0.done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    a0.mem_ready = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_abort_valid", {31'd0, a0.mem_valid}, 32'd0);
      check("post_abort_done",  {31'd0, a0.done}, 32'd0);
    end

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
